// File: rtl/wb_write_port.sv
// Register-file write port: merges the never-stalled WB result with a queued multi-cycle unit stream.
// Defining WB_FWD_EN adds a decode-stage forwarding lookup over pending writes.
module wb_write_port #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wbValid,
    input  logic [4:0]              wbReg,
    input  logic [DATA_W-1:0]       wbData,
    input  logic                    auxValid,
    output logic                    auxReady,
    input  logic [4:0]              auxReg,
    input  logic [DATA_W-1:0]       auxData,
    output logic                    wrEnable,
    output logic [4:0]              wrReg,
    output logic [DATA_W-1:0]       wrData,
    input  logic [4:0]              fwdReg1,
    input  logic [4:0]              fwdReg2,
    output logic                    fwdHit1,
    output logic                    fwdHit2,
    output logic [DATA_W-1:0]       fwdData1,
    output logic [DATA_W-1:0]       fwdData2,
    output logic [$clog2(DEPTH):0]  pendCount
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [4:0]        entryReg  [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [DEPTH-1:0]  entryValid;
    logic [DEPTH-1:0]  validNext;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W:0]    count;
    logic              wbWrite;
    logic              auxPush;
    logic              fifoPop;
    logic              headValid;

    // Writes to $0 are dropped at the door, so the queue never holds one.
    assign wbWrite   = wbValid && (wbReg != 5'd0);
    assign auxReady  = !rst && (count < FULL_COUNT);
    assign auxPush   = auxValid && auxReady && (auxReg != 5'd0);
    assign fifoPop   = !wbWrite && (count != '0);
    assign headValid = entryValid[rdPtr];
    assign pendCount = count;

    // A WB write is always younger than anything queued, including an entry landing on the same edge.
    always_comb begin
        validNext = entryValid;
        if (fifoPop) begin
            validNext[rdPtr] = 1'b0;
        end
        if (auxPush) begin
            validNext[wrPtr] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wbWrite) begin
                if (auxPush && (PTR_W'(i) == wrPtr)) begin
                    if (auxReg == wbReg) begin
                        validNext[i] = 1'b0;
                    end
                end else if (entryReg[i] == wbReg) begin
                    validNext[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (auxPush) begin
            entryReg[wrPtr]  <= auxReg;
            entryData[wrPtr] <= auxData;
        end
    end

    // Cancelled heads still pop, but leave the previous address/data on the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
            wrEnable   <= 1'b0;
            wrReg      <= '0;
            wrData     <= '0;
        end else begin
            entryValid <= validNext;
            if (auxPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (fifoPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (auxPush && !fifoPop) begin
                count <= count + COUNT_ONE;
            end else if (fifoPop && !auxPush) begin
                count <= count - COUNT_ONE;
            end
            if (wbWrite) begin
                wrEnable <= 1'b1;
                wrReg    <= wbReg;
                wrData   <= wbData;
            end else if (fifoPop && headValid) begin
                wrEnable <= 1'b1;
                wrReg    <= entryReg[rdPtr];
                wrData   <= entryData[rdPtr];
            end else begin
                wrEnable <= 1'b0;
            end
        end
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest match overrides; the output stage is oldest of all.
    function automatic logic [DATA_W:0] lookup(input logic [4:0] srcReg);
        logic [DATA_W:0]  result;
        logic [PTR_W-1:0] idx;
        result = '0;
        if (srcReg != 5'd0) begin
            if (wrEnable && (wrReg == srcReg)) begin
                result = {1'b1, wrData};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rdPtr + PTR_W'(i);
                if (entryValid[idx] && (entryReg[idx] == srcReg)) begin
                    result = {1'b1, entryData[idx]};
                end
            end
        end
        return result;
    endfunction

    always_comb begin
        {fwdHit1, fwdData1} = lookup(fwdReg1);
    end

    always_comb begin
        {fwdHit2, fwdData2} = lookup(fwdReg2);
    end
`else
    logic unusedFwd;
    assign unusedFwd = ^{fwdReg1, fwdReg2};
    assign fwdHit1   = 1'b0;
    assign fwdHit2   = 1'b0;
    assign fwdData1  = '0;
    assign fwdData2  = '0;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Directed self-checking bench for wb_write_port; forwarding expectations follow WB_FWD_EN.
module tb_wb_write_port;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam bit FWD_ON =
`ifdef WB_FWD_EN
        1'b1;
`else
        1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   wbValid;
    logic [4:0]             wbReg;
    logic [DATA_W-1:0]      wbData;
    logic                   auxValid;
    logic                   auxReady;
    logic [4:0]             auxReg;
    logic [DATA_W-1:0]      auxData;
    logic                   wrEnable;
    logic [4:0]             wrReg;
    logic [DATA_W-1:0]      wrData;
    logic [4:0]             fwdReg1;
    logic [4:0]             fwdReg2;
    logic                   fwdHit1;
    logic                   fwdHit2;
    logic [DATA_W-1:0]      fwdData1;
    logic [DATA_W-1:0]      fwdData2;
    logic [$clog2(DEPTH):0] pendCount;

    int checkCount = 0;
    int failCount  = 0;

    wb_write_port #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst(rst),
        .wbValid(wbValid),
        .wbReg(wbReg),
        .wbData(wbData),
        .auxValid(auxValid),
        .auxReady(auxReady),
        .auxReg(auxReg),
        .auxData(auxData),
        .wrEnable(wrEnable),
        .wrReg(wrReg),
        .wrData(wrData),
        .fwdReg1(fwdReg1),
        .fwdReg2(fwdReg2),
        .fwdHit1(fwdHit1),
        .fwdHit2(fwdHit2),
        .fwdData1(fwdData1),
        .fwdData2(fwdData2),
        .pendCount(pendCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkPort(input string tag, input logic en, input logic [4:0] r,
                             input logic [DATA_W-1:0] d, input logic [$clog2(DEPTH):0] cnt);
        checkOutput({tag, ".wrEnable"}, 64'(wrEnable), 64'(en));
        checkOutput({tag, ".wrReg"}, 64'(wrReg), 64'(r));
        checkOutput({tag, ".wrData"}, 64'(wrData), 64'(d));
        checkOutput({tag, ".pendCount"}, 64'(pendCount), 64'(cnt));
    endtask

    // Drive one cycle of requests, let the edge happen, then settle just past it.
    task automatic applyStimulus(input logic wbV, input logic [4:0] wbR, input logic [DATA_W-1:0] wbD,
                                 input logic auxV, input logic [4:0] auxR, input logic [DATA_W-1:0] auxD);
        wbValid  = wbV;
        wbReg    = wbR;
        wbData   = wbD;
        auxValid = auxV;
        auxReg   = auxR;
        auxData  = auxD;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fwdReg1 = 5'd0;
        fwdReg2 = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3, 'h33);
        checkPort("reset", 0, 0, 0, 0);
        checkOutput("resetReady", 64'(auxReady), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", 64'(auxReady), 64'(1));

        applyStimulus(1, 5, 'h55, 0, 0, 0);
        checkPort("wb5", 1, 5, 'h55, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("wb5Done", 0, 5, 'h55, 0);

        // WB traffic blocks draining so the queue fills.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 5'(20 + k), DATA_W'('hA0 + k), 1, 5'(1 + k), DATA_W'('h101 + k));
            checkPort($sformatf("fill%0d", k), 1, 5'(20 + k), DATA_W'('hA0 + k), 3'(k + 1));
        end
        checkOutput("fullReady", 64'(auxReady), 64'(0));
        applyStimulus(0, 0, 0, 1, 5, 'h105);
        checkPort("drain1", 1, 1, 'h101, 3);
        checkOutput("readyAfterPop", 64'(auxReady), 64'(1));
        applyStimulus(0, 0, 0, 1, 5, 'h105);
        checkPort("drain2", 1, 2, 'h102, 3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("drain3", 1, 3, 'h103, 2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("drain4", 1, 4, 'h104, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("drain5", 1, 5, 'h105, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("drainIdle", 0, 5, 'h105, 0);

        applyStimulus(0, 0, 0, 1, 7, 'hA);
        checkPort("wawQueue", 0, 5, 'h105, 1);
        applyStimulus(1, 7, 'hB, 0, 0, 0);
        checkPort("wawWb", 1, 7, 'hB, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("wawCancelPop", 0, 7, 'hB, 0);

        applyStimulus(1, 8, 'hD, 1, 8, 'hC);
        checkPort("sameEdgeWaw", 1, 8, 'hD, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("sameEdgeCancel", 0, 8, 'hD, 0);

        applyStimulus(1, 3, 'h33, 1, 4, 'h44);
        checkPort("dualWb", 1, 3, 'h33, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("dualAux", 1, 4, 'h44, 0);

        applyStimulus(1, 0, 'hFF, 1, 0, 'hEE);
        checkPort("zeroReg", 0, 4, 'h44, 0);
        checkOutput("zeroReady", 64'(auxReady), 64'(1));
        applyStimulus(0, 0, 0, 1, 6, 'h66);
        checkPort("queue6", 0, 4, 'h44, 1);
        applyStimulus(1, 0, 'hFF, 0, 0, 0);
        checkPort("wbZeroDrain", 1, 6, 'h66, 0);

        applyStimulus(1, 30, 'h1E, 1, 9, 1);
        checkPort("fwdQ1", 1, 30, 'h1E, 1);
        applyStimulus(1, 31, 'h1F, 1, 9, 2);
        checkPort("fwdQ2", 1, 31, 'h1F, 2);
        fwdReg1 = 5'd9;
        fwdReg2 = 5'd0;
        #1;
        checkOutput("fwdHit1", 64'(fwdHit1), 64'(FWD_ON));
        checkOutput("fwdData1", 64'(fwdData1), FWD_ON ? 64'(2) : 64'(0));
        checkOutput("fwdHit2Zero", 64'(fwdHit2), 64'(0));
        checkOutput("fwdData2Zero", 64'(fwdData2), 64'(0));
        fwdReg2 = 5'd31;
        #1;
        checkOutput("fwdHit2Out", 64'(fwdHit2), 64'(FWD_ON));
        checkOutput("fwdData2Out", 64'(fwdData2), FWD_ON ? 64'('h1F) : 64'(0));
        fwdReg2 = 5'd30;
        #1;
        checkOutput("fwdHit2Stale", 64'(fwdHit2), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("fwdDrain1", 1, 9, 1, 1);
        checkOutput("fwdYoungest", 64'(fwdData1), FWD_ON ? 64'(2) : 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("fwdDrain2", 1, 9, 2, 0);
        checkOutput("fwdOutStage", 64'(fwdHit1), 64'(FWD_ON));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fwdIdleHit", 64'(fwdHit1), 64'(0));

        applyStimulus(1, 11, 'hBB, 1, 10, 'hAA);
        checkPort("preReset", 1, 11, 'hBB, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("midReset", 0, 0, 0, 0);
        checkOutput("midResetReady", 64'(auxReady), 64'(0));
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkPort("postReset", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
